imem_loader: RTL and testbench

Instruction memory loader: the write-side counterpart of the 64 x 16-bit instruction memory. It receives a framed byte stream from a host link over a valid/ready handshake, assembles big-endian 16-bit instruction words, and writes them through the memory's write port starting at address 0. It holds the CPU in reset while loading, then checks an XOR checksum and reports done or error.

---
 rtl/imem_loader_if.sv | 19 +
 rtl/imem_loader.sv | 118 +++++++++++
 tb/tb_imem_loader.sv | 257 +++++++++++++++++++++++++
 3 files changed

// File: rtl/imem_loader_if.sv
// Host byte stream and instruction-memory write port bundled for the loader.
interface imem_loader_if;
  logic [7:0]  byte_in;
  logic        byte_valid;
  logic        byte_ready;
  logic        mem_we;
  logic [5:0]  mem_addr;
  logic [15:0] mem_wdata;

  modport master (
    output byte_in, byte_valid,
    input  byte_ready, mem_we, mem_addr, mem_wdata
  );

  modport slave (
    input  byte_in, byte_valid,
    output byte_ready, mem_we, mem_addr, mem_wdata
  );
endinterface

// File: rtl/imem_loader.sv
// Instruction memory loader: framed byte stream -> big-endian 16-bit words
// written from address 0, CPU held in reset meanwhile, XOR checksum at the end.
module imem_loader (
  input  logic               clk,
  input  logic               rst,
  input  logic               start,
  imem_loader_if.slave       bus,
  output logic [6:0]         words_written,
  output logic               busy,
  output logic               cpu_hold,
  output logic               done,
  output logic               err
);

  typedef enum logic [2:0] {IDLE, HDR, HI, LO, WR, CHK} state_t;

  state_t      state;
  logic        byte_ready;
  logic        mem_we;
  logic [5:0]  mem_addr;
  logic [15:0] mem_wdata;
  logic [6:0]  count;
  logic [7:0]  hi_byte;
  logic [7:0]  csum;
  logic        xfer;

  assign xfer           = bus.byte_valid && byte_ready;
  assign bus.byte_ready = byte_ready;
  assign bus.mem_we     = mem_we;
  assign bus.mem_addr   = mem_addr;
  assign bus.mem_wdata  = mem_wdata;
  assign cpu_hold       = busy;

  // byte_ready, busy and mem_we are registered alongside the state so they
  // reflect the state being entered, never byte_valid in the same cycle.
  always_ff @(posedge clk) begin
    if (rst) begin
      state         <= IDLE;
      byte_ready    <= 1'b0;
      mem_we        <= 1'b0;
      mem_addr      <= '0;
      mem_wdata     <= '0;
      words_written <= '0;
      busy          <= 1'b0;
      done          <= 1'b0;
      err           <= 1'b0;
      count         <= '0;
      hi_byte       <= '0;
      csum          <= '0;
    end else begin
      mem_we <= 1'b0;
      case (state)
        IDLE: begin
          if (start) begin
            state         <= HDR;
            byte_ready    <= 1'b1;
            busy          <= 1'b1;
            done          <= 1'b0;
            err           <= 1'b0;
            words_written <= '0;
            mem_addr      <= '0;
            csum          <= '0;
          end
        end
        HDR: begin
          if (xfer) begin
            // 0 and anything above the memory depth both mean a full load
            if (bus.byte_in == 8'd0 || bus.byte_in > 8'd64)
              count <= 7'd64;
            else
              count <= bus.byte_in[6:0];
            state <= HI;
          end
        end
        HI: begin
          if (xfer) begin
            hi_byte <= bus.byte_in;
            csum    <= csum ^ bus.byte_in;
            state   <= LO;
          end
        end
        LO: begin
          if (xfer) begin
            mem_wdata  <= {hi_byte, bus.byte_in};
            csum       <= csum ^ bus.byte_in;
            mem_we     <= 1'b1;
            byte_ready <= 1'b0;
            state      <= WR;
          end
        end
        WR: begin
          mem_addr      <= mem_addr + 6'd1;
          words_written <= words_written + 7'd1;
          byte_ready    <= 1'b1;
          if (words_written + 7'd1 == count)
            state <= CHK;
          else
            state <= HI;
        end
        CHK: begin
          if (xfer) begin
            done       <= (bus.byte_in == csum);
            err        <= (bus.byte_in != csum);
            byte_ready <= 1'b0;
            busy       <= 1'b0;
            state      <= IDLE;
          end
        end
        default: begin
          state      <= IDLE;
          byte_ready <= 1'b0;
          busy       <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_imem_loader.sv
// Directed bench for imem_loader: framed loads, bad checksum, full depth,
// gapped stream with stray start pulses, reset mid-load and idle behaviour.
module tb_imem_loader;
  logic       clk;
  logic       rst;
  logic       start;
  logic [6:0] words_written;
  logic       busy;
  logic       cpu_hold;
  logic       done;
  logic       err;

  imem_loader_if bus ();

  imem_loader dut (
    .clk           (clk),
    .rst           (rst),
    .start         (start),
    .bus           (bus.slave),
    .words_written (words_written),
    .busy          (busy),
    .cpu_hold      (cpu_hold),
    .done          (done),
    .err           (err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_chk  = 0;
  int n_fail = 0;
  int cyc    = 0;
  int tmo    = 0;

  // write monitor, sampled on the falling edge
  logic [5:0]  wr_addr [0:255];
  logic [15:0] wr_data [0:255];
  int          wr_total = 0;
  int          wr_viol  = 0;

  always @(posedge clk) cyc++;

  always @(negedge clk) begin
    if (bus.mem_we === 1'b1) begin
      if (wr_total < 256) begin
        wr_addr[wr_total] = bus.mem_addr;
        wr_data[wr_total] = bus.mem_wdata;
      end
      wr_total++;
      if (bus.byte_ready !== 1'b0) wr_viol++;
    end
  end

  logic [15:0] exp_w [0:63];
  logic [7:0]  fbuf  [0:131];
  int          fbytes;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic make_frame(input logic [7:0] hdr, input int nw, input bit bad);
    logic [7:0] cks;
    cks = 8'h00;
    fbuf[0] = hdr;
    for (int k = 0; k < nw; k++) begin
      fbuf[1 + 2*k] = exp_w[k][15:8];
      fbuf[2 + 2*k] = exp_w[k][7:0];
      cks = cks ^ exp_w[k][15:8] ^ exp_w[k][7:0];
    end
    fbuf[1 + 2*nw] = bad ? (cks ^ 8'h01) : cks;
    fbytes = 2 + 2*nw;
  endtask

  task automatic send_byte(input logic [7:0] b, input bit gaps);
    int g;
    bit got;
    g = gaps ? int'($urandom_range(0, 3)) : 0;
    repeat (g) begin
      bus.byte_valid = 1'b0;
      bus.byte_in    = 8'($urandom);
      if ($urandom_range(0, 1) == 1) start = 1'b1;
      @(posedge clk); #1;
      start = 1'b0;
    end
    bus.byte_in    = b;
    bus.byte_valid = 1'b1;
    got = 1'b0;
    for (int i = 0; i < 20 && !got; i++) begin
      @(negedge clk);
      if (bus.byte_ready === 1'b1) got = 1'b1;
      @(posedge clk); #1;
    end
    if (!got) tmo++;
    bus.byte_valid = 1'b0;
  endtask

  task automatic run_frame(input bit gaps);
    for (int i = 0; i < fbytes; i++) send_byte(fbuf[i], gaps);
  endtask

  task automatic start_load(input string tag);
    start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    chk({tag, " busy"},  32'(busy), 32'd1);
    chk({tag, " ready"}, 32'(bus.byte_ready), 32'd1);
    chk({tag, " hold"},  32'(cpu_hold), 32'd1);
    chk({tag, " clr"},   32'({done, err}), 32'd0);
  endtask

  task automatic check_writes(input string tag, input int base, input int nw);
    int bad;
    bad = 0;
    chk({tag, " wcount"}, 32'(wr_total - base), 32'(nw));
    for (int k = 0; k < nw; k++)
      if (wr_addr[base + k] !== 6'(k) || wr_data[base + k] !== exp_w[k]) bad++;
    chk({tag, " wdata"}, 32'(bad), 32'd0);
  endtask

  task automatic check_end(input string tag, input logic exp_done, input int nw);
    chk({tag, " done"}, 32'(done), 32'(exp_done));
    chk({tag, " err"},  32'(err), 32'(!exp_done));
    chk({tag, " busy"}, 32'({busy, cpu_hold}), 32'd0);
    chk({tag, " ww"},   32'(words_written), 32'(nw));
  endtask

  task automatic check_reset_state(input string tag);
    chk({tag, " ready"}, 32'(bus.byte_ready), 32'd0);
    chk({tag, " we"},    32'(bus.mem_we), 32'd0);
    chk({tag, " addr"},  32'(bus.mem_addr), 32'd0);
    chk({tag, " wdata"}, 32'(bus.mem_wdata), 32'd0);
    chk({tag, " ww"},    32'(words_written), 32'd0);
    chk({tag, " busy"},  32'({busy, cpu_hold}), 32'd0);
    chk({tag, " flags"}, 32'({done, err}), 32'd0);
  endtask

  initial begin
    int base;
    int c0;
    bit seen;
    rst = 1'b1;
    start = 1'b0;
    bus.byte_valid = 1'b0;
    bus.byte_in = 8'h00;
    repeat (3) @(posedge clk);
    start = 1'b1;                 // start together with rst must be ignored
    @(posedge clk); #1;
    start = 1'b0;
    rst = 1'b0;
    check_reset_state("reset");

    // idle: valid held without start
    base = wr_total;
    bus.byte_in = 8'hA5;
    bus.byte_valid = 1'b1;
    for (int i = 0; i < 4; i++) begin
      @(posedge clk); #1;
      chk("idle ready", 32'(bus.byte_ready), 32'd0);
      chk("idle busy",  32'(busy), 32'd0);
    end
    bus.byte_valid = 1'b0;
    chk("idle writes", 32'(wr_total - base), 32'd0);

    // basic load
    exp_w[0] = 16'h1234;
    exp_w[1] = 16'hABCD;
    make_frame(8'h02, 2, 1'b0);
    chk("basic cks byte", 32'(fbuf[5]), 32'h40);
    base = wr_total;
    start_load("basic");
    c0 = cyc;
    run_frame(1'b0);
    chk("basic cycles", 32'(cyc - c0), 32'd8);
    check_end("basic", 1'b1, 2);
    check_writes("basic", base, 2);

    // bad checksum 0x41
    make_frame(8'h02, 2, 1'b1);
    base = wr_total;
    start_load("bad");
    run_frame(1'b0);
    check_end("bad", 1'b0, 2);
    check_writes("bad", base, 2);

    // gaps, random valid and stray start pulses
    make_frame(8'h02, 2, 1'b0);
    base = wr_total;
    start_load("gap");
    run_frame(1'b1);
    check_end("gap", 1'b1, 2);
    check_writes("gap", base, 2);

    // full depth, header 0 then header 0x50
    for (int k = 0; k < 64; k++) exp_w[k] = {8'(k), ~8'(k)};
    make_frame(8'h00, 64, 1'b0);
    base = wr_total;
    start_load("full0");
    c0 = cyc;
    run_frame(1'b0);
    chk("full0 cycles", 32'(cyc - c0), 32'd194);
    check_end("full0", 1'b1, 64);
    check_writes("full0", base, 64);

    make_frame(8'h50, 64, 1'b0);
    base = wr_total;
    start_load("full50");
    run_frame(1'b0);
    check_end("full50", 1'b1, 64);
    check_writes("full50", base, 64);

    // reset after first word
    exp_w[0] = 16'h1234;
    base = wr_total;
    start_load("rstmid");
    send_byte(8'h02, 1'b0);
    send_byte(8'h12, 1'b0);
    send_byte(8'h34, 1'b0);
    seen = 1'b0;
    for (int i = 0; i < 10 && !seen; i++) begin
      @(negedge clk);
      if (wr_total - base >= 1) seen = 1'b1;
    end
    chk("rstmid first word", 32'(seen), 32'd1);
    @(posedge clk); #1;
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    check_reset_state("rstmid");
    check_writes("rstmid", base, 1);

    exp_w[0] = 16'h0001;
    make_frame(8'h01, 1, 1'b0);
    chk("one cks byte", 32'(fbuf[3]), 32'h01);
    base = wr_total;
    start_load("one");
    run_frame(1'b0);
    check_end("one", 1'b1, 1);
    check_writes("one", base, 1);

    chk("handshake timeouts", 32'(tmo), 32'd0);
    chk("ready during write", 32'(wr_viol), 32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: observed timeout expected completion");
    $fatal(1, "watchdog");
  end
endmodule
